// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) oversampling the SPI pins on the system clock.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float miso while deselected or in reset.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sck,
  input  logic                  i_mosi,
  output logic                  o_miso,
  input  logic                  i_cs,
  output logic [DATA_WIDTH-1:0] o_dr,
  input  logic [DATA_WIDTH-1:0] i_ds,
  output logic                  o_ack
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [SYNC_STAGES-1:0] r_sckSync;
  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sckPrev;
  logic                   r_csPrev;

  // The last received bit goes straight into dr, so rx only holds the first W-1 bits.
  logic [DATA_WIDTH-2:0]  r_rxShift;
  logic [DATA_WIDTH-1:0]  r_txShift;
  logic [CW-1:0]          r_bitCnt;
  logic [DATA_WIDTH-1:0]  r_dr;
  logic                   r_ack;

  logic w_sck;
  logic w_cs;
  logic w_mosi;
  logic w_sckRise;
  logic w_sckFall;
  logic w_csFall;
  logic w_lastBit;

  // cs presets high so reset looks like an idle, deselected bus.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sckSync  <= '0;
      r_csSync   <= '1;
      r_mosiSync <= '0;
      r_sckPrev  <= 1'b0;
      r_csPrev   <= 1'b1;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], i_sck};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], i_cs};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], i_mosi};
      r_sckPrev  <= w_sck;
      r_csPrev   <= w_cs;
    end
  end

  assign w_sck     = r_sckSync[SYNC_STAGES-1];
  assign w_cs      = r_csSync[SYNC_STAGES-1];
  assign w_mosi    = r_mosiSync[SYNC_STAGES-1];
  assign w_sckRise = w_sck & ~r_sckPrev;
  assign w_sckFall = ~w_sck & r_sckPrev;
  assign w_csFall  = ~w_cs & r_csPrev;
  assign w_lastBit = (r_bitCnt == CW'(DATA_WIDTH - 1));

  // A deselected bus holds the counter and partial word cleared, which aborts any transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxShift <= '0;
      r_txShift <= '0;
      r_bitCnt  <= '0;
      r_dr      <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_csFall) begin
        r_txShift <= i_ds;
        r_rxShift <= '0;
        r_bitCnt  <= '0;
      end else if (w_cs) begin
        r_rxShift <= '0;
        r_bitCnt  <= '0;
      end else begin
        if (w_sckRise) begin
          r_rxShift <= {r_rxShift[DATA_WIDTH-3:0], w_mosi};
          if (w_lastBit) begin
            r_dr     <= {r_rxShift, w_mosi};
            r_ack    <= 1'b1;
            r_bitCnt <= '0;
          end else begin
            r_bitCnt <= r_bitCnt + CW'(1);
          end
        end
        if (w_sckFall) begin
          if (r_bitCnt == '0) begin
            r_txShift <= i_ds;
          end else begin
            r_txShift <= r_txShift << 1;
          end
        end
      end
    end
  end

  assign o_dr  = r_dr;
  assign o_ack = r_ack;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_miso = w_cs ? 1'bz : r_txShift[DATA_WIDTH-1];
`else
  assign o_miso = w_cs ? 1'b0 : r_txShift[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus randomized multi-word transfers
// checked against a word-level model of what the master should see.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       i_clk;
  logic       i_rst;
  logic       i_sck;
  logic       i_mosi;
  logic       o_miso;
  logic       i_cs;
  logic [7:0] o_dr;
  logic [7:0] i_ds;
  logic       o_ack;

  int         checks;
  int         errors;
  int         ackCount;
  int         ackDouble;
  int         expAcks;
  logic       ackPrev;
  logic [7:0] drAtAck;
  logic [7:0] refDr;
  logic       expIdle;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sck (i_sck),
    .i_mosi(i_mosi),
    .o_miso(o_miso),
    .i_cs  (i_cs),
    .o_dr  (o_dr),
    .i_ds  (i_ds),
    .o_ack (o_ack)
  );

  // 10-unit system clock; sck half period is HALF system clocks.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Record every ack pulse and the word it publishes; flag pulses longer than one clock.
  initial begin
    ackCount  = 0;
    ackDouble = 0;
    ackPrev   = 1'b0;
    drAtAck   = 8'h00;
    forever begin
      @(negedge i_clk);
      if (o_ack) begin
        ackCount = ackCount + 1;
        drAtAck  = o_dr;
        if (ackPrev) ackDouble = ackDouble + 1;
      end
      ackPrev = o_ack;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Master side of one word: mosi set while sck low, miso sampled just before each rise.
  task automatic applyStimulus(input logic [7:0] mosiByte, input logic [7:0] expMiso,
                               input logic [7:0] dsNext, input int nBits);
    logic [7:0] got;
    got = 8'h00;
    for (int i = 7; i >= 8 - nBits; i--) begin
      i_mosi = mosiByte[i];
      repeat (HALF) @(negedge i_clk);
      got[i] = o_miso;
      i_sck = 1'b1;
      repeat (HALF) @(negedge i_clk);
      if (i == 4) i_ds = dsNext;
      i_sck = 1'b0;
    end
    if (nBits == 8) begin
      expAcks = expAcks + 1;
      refDr   = mosiByte;
      checkOutput("miso_word", {24'h0, got}, {24'h0, expMiso});
      checkOutput("ack_count", ackCount, expAcks);
      checkOutput("dr_at_ack", {24'h0, drAtAck}, {24'h0, refDr});
      checkOutput("dr_hold", {24'h0, o_dr}, {24'h0, refDr});
    end
  endtask

  task automatic csLow(input logic [7:0] dsFirst);
    i_ds = dsFirst;
    @(negedge i_clk);
    i_cs = 1'b0;
    repeat (HALF) @(negedge i_clk);
    checkOutput("miso_first_bit", {31'h0, o_miso}, {31'h0, dsFirst[7]});
  endtask

  task automatic csHigh();
    repeat (HALF) @(negedge i_clk);
    i_cs = 1'b1;
    repeat (HALF) @(negedge i_clk);
    checkOutput("miso_idle", {31'h0, o_miso}, {31'h0, expIdle});
    checkOutput("dr_after_cs", {24'h0, o_dr}, {24'h0, refDr});
    checkOutput("ack_after_cs", ackCount, expAcks);
  endtask

  initial begin
    logic [7:0] dsCur;
    logic [7:0] dsN;
    logic [7:0] b;
    int         nWords;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    expIdle = 1'bz;
`else
    expIdle = 1'b0;
`endif
    checks  = 0;
    errors  = 0;
    expAcks = 0;
    refDr   = 8'h00;
    i_rst   = 1'b1;
    i_sck   = 1'b0;
    i_mosi  = 1'b0;
    i_cs    = 1'b1;
    i_ds    = 8'h00;

    repeat (4) @(negedge i_clk);
    checkOutput("reset_dr", {24'h0, o_dr}, 32'h0);
    checkOutput("reset_ack", {31'h0, o_ack}, 32'h0);
    checkOutput("reset_miso", {31'h0, o_miso}, {31'h0, expIdle});
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);

    $display("[TB] single word 0xF0 with ds=0xAA");
    csLow(8'hAA);
    checkOutput("dr_before_word", {24'h0, o_dr}, 32'h0);
    applyStimulus(8'hF0, 8'hAA, 8'hAA, 8);
    csHigh();

    $display("[TB] back-to-back words 0x3C, 0xC3");
    csLow(8'h5A);
    applyStimulus(8'h3C, 8'h5A, 8'h81, 8);
    applyStimulus(8'hC3, 8'h81, 8'h81, 8);
    csHigh();

    $display("[TB] aborted word then 0x12");
    csLow(8'h77);
    applyStimulus(8'hFF, 8'h77, 8'h77, 5);
    csHigh();
    csLow(8'h0F);
    applyStimulus(8'h12, 8'h0F, 8'h0F, 8);
    csHigh();

    $display("[TB] sck toggling while deselected");
    for (int k = 0; k < 16; k++) begin
      i_mosi = 1'($urandom);
      i_sck  = ~i_sck;
      repeat (HALF) @(negedge i_clk);
      checkOutput("miso_desel", {31'h0, o_miso}, {31'h0, expIdle});
    end
    checkOutput("dr_desel", {24'h0, o_dr}, {24'h0, refDr});
    checkOutput("ack_desel", ackCount, expAcks);

    $display("[TB] reset during a word");
    csLow(8'hC5);
    applyStimulus(8'hA5, 8'hC5, 8'hC5, 4);
    i_rst = 1'b1;
    i_cs  = 1'b1;
    #1;
    refDr = 8'h00;
    checkOutput("rst_mid_dr", {24'h0, o_dr}, 32'h0);
    checkOutput("rst_mid_ack", {31'h0, o_ack}, 32'h0);
    checkOutput("rst_mid_miso", {31'h0, o_miso}, {31'h0, expIdle});
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (HALF) @(negedge i_clk);
    csLow(8'h3E);
    applyStimulus(8'h96, 8'h3E, 8'h3E, 8);
    csHigh();

    $display("[TB] randomized transfers");
    for (int t = 0; t < 8; t++) begin
      nWords = int'($urandom_range(1, 3));
      dsCur  = 8'($urandom);
      csLow(dsCur);
      for (int w = 0; w < nWords; w++) begin
        b   = 8'($urandom);
        dsN = 8'($urandom);
        applyStimulus(b, dsCur, dsN, 8);
        dsCur = dsN;
      end
      csHigh();
    end

    checkOutput("ack_single_cycle", ackDouble, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
